spi_master_xfer: RTL and testbench

//  SPI initiator: shifts out one FRAME_BITS-wide word on SCK/SSEL/MOSI, captures MISO.

---
 rtl/spi_master_xfer_pkg.sv | 24 ++
 rtl/spi_master_xfer_if.sv | 27 ++
 rtl/spi_master_xfer_sync_2ff.sv | 23 ++
 rtl/spi_master_xfer.sv | 131 +++++++++++++
 tb/tb_spi_master_xfer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_xfer_pkg.sv
// Shared definitions for the mode-3 SPI initiator: state encoding, SPI mode and default sizing.
package spi_master_xfer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOW,
      ST_HIGH,
      ST_GAP
   } state_t;

   localparam bit SPI_CPOL = 1'b1;
   localparam bit SPI_CPHA = 1'b1;

   localparam int DEF_FRAME_BITS = 32;
   localparam int DEF_HALF_DIV   = 16;
   localparam int DEF_GAP_CYCLES = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_xfer_if.sv
// Host handshake plus SPI pins of the initiator, bundled for port connection.
interface spi_master_xfer_if
   import spi_master_xfer_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS
);
   logic                  start;
   logic [FRAME_BITS-1:0] tx_data;
   logic                  busy;
   logic                  done;
   logic [FRAME_BITS-1:0] rx_data;
   logic                  sck;
   logic                  ssel;
   logic                  mosi;
   logic                  miso;

   modport master (
      input  start, tx_data, miso,
      output busy, done, rx_data, sck, ssel, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  busy, done, rx_data, sck, ssel, mosi
   );

endinterface

// File: rtl/spi_master_xfer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; clears to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/spi_master_xfer.sv
// Mode-3 SPI initiator: one FRAME_BITS word per SSEL-low frame, MSB first,
// with a start/busy/done host handshake. All SPI pins come straight from registers.
module spi_master_xfer
   import spi_master_xfer_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int HALF_DIV   = DEF_HALF_DIV,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input logic               clk,
   input logic               rst_n,
   spi_master_xfer_if.master bus
);
   localparam int HC_W = width_of(HALF_DIV);
   localparam int BC_W = width_of(FRAME_BITS + 1);
   localparam int GC_W = width_of(GAP_CYCLES + 1);

   state_t                state_reg, state_next;
   logic [HC_W-1:0]       hc_reg;
   logic [BC_W-1:0]       bitcnt_reg;
   logic [GC_W-1:0]       gc_reg;
   logic [FRAME_BITS-1:0] tx_shift_reg;
   logic [FRAME_BITS-1:0] rx_shift_reg;
   logic [FRAME_BITS-1:0] rx_data_reg;
   logic                  sck_reg, ssel_reg, mosi_reg, busy_reg, done_reg;
   logic                  miso_sync;
   logic                  half_end, last_bit, gap_end;

   sync_2ff u_miso_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.miso),
      .q     (miso_sync)
   );

   assign half_end = (hc_reg == HC_W'(HALF_DIV - 1));
   assign last_bit = (bitcnt_reg == BC_W'(FRAME_BITS));
   // The gap state always spends one extra cycle committing rx_data, so GAP_CYCLES=0 still visits it.
   assign gap_end  = (gc_reg == GC_W'(GAP_CYCLES));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (bus.start) state_next = ST_SETUP;
         ST_SETUP: if (half_end)  state_next = ST_LOW;
         ST_LOW:   if (half_end)  state_next = ST_HIGH;
         ST_HIGH:  if (half_end)  state_next = last_bit ? ST_GAP : ST_LOW;
         ST_GAP:   if (gap_end)   state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_reg       <= '0;
         bitcnt_reg   <= '0;
         gc_reg       <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         sck_reg      <= SPI_CPOL;
         ssel_reg     <= 1'b1;
         mosi_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         hc_reg   <= '0;
         gc_reg   <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  // tx_shift holds the bits still to be driven, next one at the top.
                  tx_shift_reg <= bus.tx_data << 1;
                  mosi_reg     <= bus.tx_data[FRAME_BITS-1];
                  ssel_reg     <= 1'b0;
                  busy_reg     <= 1'b1;
                  bitcnt_reg   <= '0;
               end
            end
            ST_SETUP: begin
               hc_reg <= half_end ? '0 : hc_reg + HC_W'(1);
               if (half_end) sck_reg <= ~SPI_CPOL;
            end
            ST_LOW: begin
               hc_reg <= half_end ? '0 : hc_reg + HC_W'(1);
               if (half_end) begin
                  sck_reg      <= SPI_CPOL;
                  rx_shift_reg <= FRAME_BITS'({rx_shift_reg, miso_sync});
                  bitcnt_reg   <= bitcnt_reg + BC_W'(1);
               end
            end
            ST_HIGH: begin
               hc_reg <= half_end ? '0 : hc_reg + HC_W'(1);
               if (half_end) begin
                  if (!last_bit) begin
                     sck_reg      <= ~SPI_CPOL;
                     mosi_reg     <= tx_shift_reg[FRAME_BITS-1];
                     tx_shift_reg <= tx_shift_reg << 1;
                  end else begin
                     ssel_reg <= 1'b1;
                     mosi_reg <= 1'b0;
                  end
               end
            end
            ST_GAP: begin
               gc_reg <= gap_end ? '0 : gc_reg + GC_W'(1);
               if (gap_end) begin
                  rx_data_reg <= rx_shift_reg;
                  done_reg    <= 1'b1;
                  busy_reg    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sck     = sck_reg;
   assign bus.ssel    = ssel_reg;
   assign bus.mosi    = mosi_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: a default 32-bit instance with a mode-3 slave model and an
// 8-bit HALF_DIV=4/GAP=0 instance in MOSI->MISO loop-back, both checked every cycle.
module tb_spi_master_xfer;

   localparam int A_FB = 32, A_HD = 16, A_GAP = 16;
   localparam int B_FB = 8,  B_HD = 4,  B_GAP = 0;
   localparam int LAT_A = 2 + A_HD * (1 + 2 * A_FB) + A_GAP;
   localparam int LAT_B = 2 + B_HD * (1 + 2 * B_FB) + B_GAP;
   localparam int WAIT_LIMIT = 3000;

   typedef struct packed {
      logic sck;
      logic ssel;
      logic mosi;
      logic busy;
      logic done;
   } lines_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   spi_master_xfer_if #(.FRAME_BITS(A_FB)) if_a ();
   spi_master_xfer_if #(.FRAME_BITS(B_FB)) if_b ();

   spi_master_xfer #(.FRAME_BITS(A_FB), .HALF_DIV(A_HD), .GAP_CYCLES(A_GAP)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a.master)
   );

   spi_master_xfer #(.FRAME_BITS(B_FB), .HALF_DIV(B_HD), .GAP_CYCLES(B_GAP)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b.master)
   );

   assign if_b.miso = if_b.mosi;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Pin levels k cycles after the start cycle, from the frame arithmetic alone.
   function automatic lines_t model_lines(input int k, input int hd, input int fb,
                                          input int gap, input logic [31:0] tx);
      lines_t r;
      int lat, ssel_end, b;
      lat      = 2 + hd * (1 + 2 * fb) + gap;
      ssel_end = hd * (1 + 2 * fb);
      r = '{sck: 1'b1, ssel: 1'b1, mosi: 1'b0, busy: 1'b0, done: 1'b0};
      if (k >= 1 && k < lat) r.busy = 1'b1;
      if (k == lat)          r.done = 1'b1;
      if (k >= 1 && k <= ssel_end) begin
         r.ssel = 1'b0;
         b      = (k <= hd) ? 0 : (k - 1 - hd) / (2 * hd);
         r.mosi = tx[fb - 1 - b];
         if (k > hd) r.sck = (((k - 1 - hd) / hd) % 2) == 1;
      end
      return r;
   endfunction

   // Mode-3 slave for instance A: loads its word on SSEL fall, shifts out on each SCK fall.
   logic [31:0] slave_word_a = '0;
   logic [31:0] slave_sh;
   always @(negedge if_a.sck or negedge if_a.ssel) begin
      if (!if_a.ssel) begin
         if (if_a.sck) begin
            slave_sh  = slave_word_a;
            if_a.miso = 1'b0;
         end else begin
            if_a.miso = slave_sh[31];
            slave_sh  = slave_sh << 1;
         end
      end
   end

   // Reference model state and frame-shape monitors.
   int          t0a = -1, t0b = -1, ka, kb;
   logic [31:0] txa_m = '0, slva_m = '0, rxa_exp = '0;
   logic [7:0]  txb_m = '0, rxb_exp = '0;
   lines_t      ea, eb;
   logic        prev_sck_a = 1'b1, prev_ssel_a = 1'b1;
   int          rises_a = 0, ssel_low_a = 0, high_run_a = 0, gap_last_a = 0;
   logic [31:0] mosi_cap_a = '0;
   int          done_cnt_a = 0, done_cnt_b = 0;

   always @(negedge clk) begin
      ka = (t0a < 0) ? -1 : cyc - t0a;
      kb = (t0b < 0) ? -1 : cyc - t0b;
      ea = model_lines(rst_n ? ka : -1, A_HD, A_FB, A_GAP, txa_m);
      eb = model_lines(rst_n ? kb : -1, B_HD, B_FB, B_GAP, {24'h0, txb_m});
      if (!rst_n) begin
         rxa_exp = '0;
         rxb_exp = '0;
      end else begin
         if (ea.done) rxa_exp = slva_m;
         if (eb.done) rxb_exp = txb_m;
      end
      chk("lines_a", 32'({if_a.sck, if_a.ssel, if_a.mosi, if_a.busy, if_a.done}), 32'(ea));
      chk("rx_a", if_a.rx_data, rxa_exp);
      chk("lines_b", 32'({if_b.sck, if_b.ssel, if_b.mosi, if_b.busy, if_b.done}), 32'(eb));
      chk("rx_b", 32'(if_b.rx_data), 32'(rxb_exp));

      if (!if_a.ssel) begin
         if (prev_ssel_a) begin
            gap_last_a = high_run_a;
            rises_a    = 0;
            ssel_low_a = 0;
            mosi_cap_a = '0;
         end
         ssel_low_a++;
         if (!prev_sck_a && if_a.sck) begin
            rises_a++;
            mosi_cap_a = {mosi_cap_a[30:0], if_a.mosi};
         end
      end else begin
         if (!prev_ssel_a) high_run_a = 0;
         high_run_a++;
      end
      prev_sck_a  = if_a.sck;
      prev_ssel_a = if_a.ssel;
      if (if_a.done) done_cnt_a++;
      if (if_b.done) done_cnt_b++;

      if (!rst_n) begin
         t0a = -1;
         t0b = -1;
      end else begin
         if (if_a.start && (ka < 0 || ka >= LAT_A)) begin
            t0a = cyc; txa_m = if_a.tx_data; slva_m = slave_word_a;
         end
         if (if_b.start && (kb < 0 || kb >= LAT_B)) begin
            t0b = cyc; txb_m = if_b.tx_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int which, input logic [31:0] tx, input logic [31:0] word,
                              output int st);
      if (which == 0) begin
         slave_word_a = word;
         if_a.tx_data = tx;
         if_a.start   = 1'b1;
      end else begin
         if_b.tx_data = tx[7:0];
         if_b.start   = 1'b1;
      end
      st = cyc;
      tick(1);
      if_a.start   = 1'b0;
      if_b.start   = 1'b0;
      if_a.tx_data = $urandom();
      if_b.tx_data = 8'($urandom());
   endtask

   task automatic stray_start(input int which);
      if (which == 0) begin if_a.start = 1'b1; if_a.tx_data = $urandom(); end
      else            begin if_b.start = 1'b1; if_b.tx_data = 8'($urandom()); end
      tick(1);
      if_a.start = 1'b0;
      if_b.start = 1'b0;
   endtask

   // Returns in the done cycle (just after its rising clock edge).
   task automatic wait_done(input int which, input int st, output int lat);
      int n = 0;
      while (!((which == 0) ? if_a.done : if_b.done) && n < WAIT_LIMIT) begin
         tick(1);
         n++;
      end
      if (n >= WAIT_LIMIT) begin
         checks++;
         errors++;
         $display("FAIL wait_done_%0d: no done within %0d cycles", which, WAIT_LIMIT);
      end
      lat = cyc - st;
   endtask

   int st, lat, dc0, n;
   logic [31:0] w;

   initial begin
      rst_n = 1'b0;
      if_a.start = 1'b0; if_a.tx_data = '0;
      if_b.start = 1'b0; if_b.tx_data = '0;
      tick(3);
      chk("rst_lines_a", 32'({if_a.sck, if_a.ssel, if_a.mosi, if_a.busy, if_a.done}), 32'h18);
      chk("rst_rx_a", if_a.rx_data, 32'h0);
      rst_n = 1'b1;
      tick(2);

      // Long idle: lines parked, no done.
      dc0 = done_cnt_a + done_cnt_b;
      tick(2000);
      chk("idle_done", 32'(done_cnt_a + done_cnt_b - dc0), 32'd0);
      chk("idle_lines_a", 32'({if_a.sck, if_a.ssel, if_a.mosi}), 32'h6);

      // Reference frame with hand-computed shape.
      start_frame(0, 32'h80CC0000, 32'hA5A50F0F, st);
      wait_done(0, st, lat);
      chk("t1_latency", 32'(lat), 32'd1058);
      chk("t1_rx", if_a.rx_data, 32'hA5A50F0F);
      chk("t1_mosi", mosi_cap_a, 32'h80CC0000);
      chk("t1_rises", 32'(rises_a), 32'd32);
      chk("t1_ssel_low", 32'(ssel_low_a), 32'd1040);
      tick(3);

      // Stray start mid-frame is ignored.
      dc0 = done_cnt_a;
      start_frame(0, $urandom(), $urandom(), st);
      tick(99);
      chk("t2_busy_mid", 32'(if_a.busy), 32'd1);
      stray_start(0);
      wait_done(0, st, lat);
      chk("t2_latency", 32'(lat), 32'd1058);
      tick(3);
      chk("t2_done_count", 32'(done_cnt_a - dc0), 32'd1);

      // Back-to-back: second start in the done cycle. SSEL high time between frames is
      // latency minus SSEL-low time: 1058 - 1040 = 18.
      start_frame(0, 32'hFFFFFFFF, 32'h12345678, st);
      wait_done(0, st, lat);
      start_frame(0, 32'h00000000, 32'hFEDCBA98, st);
      chk("t3_busy_next", 32'(if_a.busy), 32'd1);
      wait_done(0, st, lat);
      chk("t3_latency", 32'(lat), 32'd1058);
      chk("t3_gap", 32'(gap_last_a), 32'd18);
      chk("t3_rx", if_a.rx_data, 32'hFEDCBA98);
      tick(5);

      // Reset during the 10th bit's high phase.
      dc0 = done_cnt_a;
      start_frame(0, $urandom(), $urandom(), st);
      n = 0;
      while (rises_a < 10 && n < WAIT_LIMIT) begin tick(1); n++; end
      chk("t4_reach_rise10", 32'(rises_a >= 10), 32'd1);
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_lines", 32'({if_a.sck, if_a.ssel, if_a.mosi, if_a.busy, if_a.done}), 32'h18);
      chk("t4_rst_rx", if_a.rx_data, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("t4_no_done", 32'(done_cnt_a - dc0), 32'd0);
      start_frame(0, 32'h0F0F1234, 32'h55AA33CC, st);
      wait_done(0, st, lat);
      chk("t4_latency", 32'(lat), 32'd1058);
      chk("t4_rx", if_a.rx_data, 32'h55AA33CC);

      // Randomized frames on instance A, some with stray starts, some back-to-back.
      for (int i = 0; i < 3; i++) begin
         w = $urandom();
         start_frame(0, $urandom(), w, st);
         if ($urandom_range(0, 1) == 1) begin
            tick($urandom_range(1, 1000));
            stray_start(0);
         end
         wait_done(0, st, lat);
         chk("rand_a_latency", 32'(lat), 32'(LAT_A));
         chk("rand_a_rx", if_a.rx_data, w);
         if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 20));
      end
      tick(3);

      // Short configuration, loop-back.
      start_frame(1, 32'h5A, 32'h0, st);
      wait_done(1, st, lat);
      chk("t5_latency", 32'(lat), 32'd70);
      chk("t5_rx", 32'(if_b.rx_data), 32'h5A);
      for (int i = 0; i < 8; i++) begin
         w = 32'($urandom_range(0, 255));
         start_frame(1, w, 32'h0, st);
         if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(1, 60));
            stray_start(1);
         end
         wait_done(1, st, lat);
         chk("rand_b_latency", 32'(lat), 32'(LAT_B));
         chk("rand_b_rx", 32'(if_b.rx_data), w);
         if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 10));
      end
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
